// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: one pipeline-stage register (PC, instruction, sideband)
// with a valid/ready handshake, a 2-entry skid buffer (main + skid) so that
// in_ready is registered, synchronous flush to a NOP bubble, stall as a
// downstream hold, and a saturating bubble counter for CPI debug.
//
// Handshake: a beat moves across an interface on a rising edge only when its
// valid and ready are both 1 in the cycle before that edge. The sender holds
// the payload stable until that happens. Here in_ready depends only on
// registered state, never combinationally on out_ready. stall behaves exactly
// as if out_ready were 0.
module pipe_stage_skid #(
    parameter int                 PC_W     = 32,
    parameter int                 INST_W   = 32,
    parameter int                 SB_W     = 8,
    // sll $0,$0,0 encodes as all zeros
    parameter logic [INST_W-1:0]  NOP_INST = '0,
    parameter int                 CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              stall,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [INST_W-1:0] in_inst,
    input  logic [SB_W-1:0]   in_sb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [SB_W-1:0]   out_sb,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Skid entry: holds the beat accepted while main was stuck.
    logic              skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic [SB_W-1:0]   skid_sb;

    // Next-state values.
    logic              main_valid_n;
    logic [PC_W-1:0]   main_pc_n;
    logic [INST_W-1:0] main_inst_n;
    logic [SB_W-1:0]   main_sb_n;
    logic              skid_valid_n;
    logic [PC_W-1:0]   skid_pc_n;
    logic [INST_W-1:0] skid_inst_n;
    logic [SB_W-1:0]   skid_sb_n;

    logic acc_in;
    logic acc_out;
    logic main_free;

    assign acc_in    = in_valid & in_ready;
    assign acc_out   = out_valid & out_ready & ~stall;
    // Main can take a new beat this edge if it is empty or is being drained.
    assign main_free = ~out_valid | acc_out;

    // Next-state selection for main and skid; flush overrides everything.
    always_comb begin
        main_valid_n = out_valid;
        main_pc_n    = out_pc;
        main_inst_n  = out_inst;
        main_sb_n    = out_sb;
        skid_valid_n = skid_valid;
        skid_pc_n    = skid_pc;
        skid_inst_n  = skid_inst;
        skid_sb_n    = skid_sb;

        if (flush) begin
            main_valid_n = 1'b0;
            main_pc_n    = '0;
            main_inst_n  = NOP_INST;
            main_sb_n    = '0;
            skid_valid_n = 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                // Oldest beat lives in skid, so it moves up first.
                main_valid_n = 1'b1;
                main_pc_n    = skid_pc;
                main_inst_n  = skid_inst;
                main_sb_n    = skid_sb;
                if (acc_in) begin
                    skid_valid_n = 1'b1;
                    skid_pc_n    = in_pc;
                    skid_inst_n  = in_inst;
                    skid_sb_n    = in_sb;
                end else begin
                    skid_valid_n = 1'b0;
                end
            end else if (acc_in) begin
                main_valid_n = 1'b1;
                main_pc_n    = in_pc;
                main_inst_n  = in_inst;
                main_sb_n    = in_sb;
            end else begin
                // Going empty: present a NOP, keep the last PC.
                main_valid_n = 1'b0;
                main_inst_n  = NOP_INST;
                main_sb_n    = '0;
            end
        end else if (acc_in) begin
            // Main is stuck; park the incoming beat in skid.
            skid_valid_n = 1'b1;
            skid_pc_n    = in_pc;
            skid_inst_n  = in_inst;
            skid_sb_n    = in_sb;
        end
    end

    // Register main, skid and the registered in_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_pc     <= '0;
            out_inst   <= NOP_INST;
            out_sb     <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_inst  <= NOP_INST;
            skid_sb    <= '0;
            in_ready   <= 1'b1;
        end else begin
            out_valid  <= main_valid_n;
            out_pc     <= main_pc_n;
            out_inst   <= main_inst_n;
            out_sb     <= main_sb_n;
            skid_valid <= skid_valid_n;
            skid_pc    <= skid_pc_n;
            skid_inst  <= skid_inst_n;
            skid_sb    <= skid_sb_n;
            in_ready   <= ~skid_valid_n;
        end
    end

    // Count cycles with no valid output, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID latch: one pipeline-stage register carrying PC, instruction and a sideband field between any two MIPS stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake and a 2-entry skid buffer, so in_ready is a registered signal.
- Synchronous flush inserts a NOP bubble; stall holds the output.
- A saturating bubble counter supports CPI debug.

Parameters:
PC_W, 32, width of PC field
INST_W, 32, width of instruction field
SB_W, 8, width of sideband (control bits, exception code)
NOP_INST, 32'h0000_0000, instruction value driven whenever out_valid=0 (sll $0,$0,0)
CNT_W, 16, width of bubble counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous squash of all held entries (branch/jump taken)
stall  in  1  hazard-unit hold; blocks downstream transfer
in_valid  in  1  upstream payload valid
in_ready  out  1  registered; stage can accept
in_pc  in  PC_W  upstream PC
in_inst  in  INST_W  upstream instruction
in_sb  in  SB_W  upstream sideband
out_valid  out  1  output payload valid
out_ready  in  1  downstream can accept
out_pc  out  PC_W  registered PC
out_inst  out  INST_W  registered instruction
out_sb  out  SB_W  registered sideband
bubble_cnt  out  CNT_W  saturating count of cycles with out_valid=0

Behaviour:
- Reset (rst_n=0, async, takes effect immediately) sets: out_valid=0, out_pc=0, out_inst=NOP_INST, out_sb=0, skid_valid=0, in_ready=1, bubble_cnt=0.
- Definitions:
  - acc_in = in_valid & in_ready.
  - acc_out = out_valid & out_ready & ~stall.
  - stall is equivalent to forcing out_ready=0.
- Storage: main register (drives outputs) and skid register. The skid register is written only when main is occupied and not draining.
- Per rising edge, flush=0:
  - main empty, or acc_out: if skid_valid, main<=skid. Also skid<=input if acc_in, else skid_valid<=0. If skid empty, main<=input when acc_in, else out_valid<=0.
  - main full and no acc_out: if acc_in, skid<=input and skid_valid<=1.
- in_ready next value = ~skid_valid_next. It is never combinationally dependent on out_ready.
- Latency: 1 cycle input to output when not back-pressured. Throughput is 1 per cycle under continuous out_ready=1.
- Flush (highest priority over stall and handshake):
  - Next cycle: out_valid=0, skid_valid=0, in_ready=1.
  - The beat accepted in the flush cycle is discarded.
  - Payload forced to pc=0, inst=NOP_INST, sb=0.
- Whenever out_valid=0, out_inst=NOP_INST and out_sb=0. out_pc is unspecified-but-stable (hold last).
- Ordering: strict FIFO; no beat is ever duplicated or reordered.
- bubble_cnt increments on each clock with out_valid=0. It saturates at 2^CNT_W-1 and is cleared only by reset.
- Flush and stall in the same cycle: flush wins; the stage empties.
- Reset mid-transfer: the in-flight beat is lost, with no partial state.

Test Plan:
- Reset, then release: out_valid=0, out_inst=0, in_ready=1, bubble_cnt counts 1,2,3… while idle.
- Stream pc=0x00400000+4k, k=0..7, in_valid=1, out_ready=1: outputs appear 1 cycle later in order, with no gaps.
- Present pc=0x100, 0x104, 0x108 with stall=1 from cycle 1:
  - 0x100 held on the output.
  - 0x104 goes to skid.
  - in_ready=0 one cycle after skid fills; 0x108 is held upstream.
  - On stall release, order is 0x100, 0x104, 0x108 with no loss.
- With main=0x200 and skid=0x204 full, assert flush together with in_valid (pc=0x208): next cycle out_valid=0, out_inst=NOP_INST, in_ready=1. 0x208 never appears.
- flush=1 and stall=1 simultaneously with both entries full: the stage empties, identical to flush alone.
- Assert rst_n=0 asynchronously mid-stream between edges: outputs go to reset values immediately. After release, the first new beat passes normally.
- CNT_W=4, idle for 20 cycles: bubble_cnt saturates at 15.
